divider_controller: RTL and testbench

Sequencing FSM for the 8-bit ÷ 7-bit restoring divider. It sits directly upstream of the divider datapath and drives that datapath's `load`, `add`, `shift`, `inbit` and `sel` controls. It consumes the datapath's `sign` flag and signals completion to the system with a `start`/`busy`/`done` handshake. Quotient and remainder are read directly from the datapath outputs.

---
 rtl/divider_controller.sv | 181 ++++++++++++++++++
 tb/tb_divider_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/divider_controller.sv
// divider_controller: sequencing FSM for an 8-bit / 7-bit restoring divider.
// Drives the datapath load/add/shift/inbit/sel controls from a Moore FSM and
// reports completion with a start/busy/done handshake.
// Optional feature: define DIVCTRL_DIVZERO_EN to add the div0 output and a
// short-circuit of zero-divisor requests straight to DONE.
module divider_controller #(
  parameter int unsigned ITER = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] divisorin,
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
`ifdef DIVCTRL_DIVZERO_EN
  ,
  output logic       div0
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SUB,
    S_RESTORE,
    S_SHIFT1,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        load_q, load_d;
  logic        add_q, add_d;
  logic        shift_q, shift_d;
  logic        inbit_q, inbit_d;
  logic [1:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef DIVCTRL_DIVZERO_EN
  logic        div0_q, div0_d;
`else
  logic        unused_divisorin;
  assign unused_divisorin = ^divisorin;
`endif

  // Next-state and iteration-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DIVCTRL_DIVZERO_EN
    div0_d  = div0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DIVCTRL_DIVZERO_EN
          div0_d  = (divisorin == '0);
          state_d = (divisorin == '0) ? S_DONE : S_INIT;
`else
          state_d = S_INIT;
`endif
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_SUB;
      end
      S_SUB: begin
        state_d = sign ? S_RESTORE : S_SHIFT1;
      end
      S_RESTORE, S_SHIFT1: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_SUB;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // track the state register exactly (Moore behaviour without a decode stage).
  always_comb begin
    load_d  = 1'b0;
    add_d   = 1'b0;
    shift_d = 1'b0;
    inbit_d = 1'b0;
    sel_d   = 2'd3;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_INIT: begin
        load_d  = 1'b1;
        sel_d   = 2'd2;
        shift_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_SUB: begin
        sel_d   = 2'd1;
        busy_d  = 1'b1;
      end
      S_RESTORE: begin
        sel_d   = 2'd1;
        add_d   = 1'b1;
        shift_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_SHIFT1: begin
        sel_d   = 2'd3;
        shift_d = 1'b1;
        inbit_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counter and registered outputs; reset restores idle defaults at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      inbit_q <= 1'b0;
      sel_q   <= 2'd3;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVCTRL_DIVZERO_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      add_q   <= add_d;
      shift_q <= shift_d;
      inbit_q <= inbit_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIVCTRL_DIVZERO_EN
      div0_q  <= div0_d;
`endif
    end
  end

  assign load  = load_q;
  assign add   = add_q;
  assign shift = shift_q;
  assign inbit = inbit_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef DIVCTRL_DIVZERO_EN
  assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench for divider_controller with a behavioural datapath.
module tb_divider_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] divisorin = '0;
  logic [7:0] dividendin = '0;
  logic       sign;
  logic       load, add, shift, inbit, busy, done;
  logic [1:0] sel;
`ifdef DIVCTRL_DIVZERO_EN
  logic       div0;
`endif

  always #5 clk = ~clk;

  divider_controller #(.ITER(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .divisorin (divisorin),
    .sign      (sign),
    .load      (load),
    .add       (add),
    .shift     (shift),
    .inbit     (inbit),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
`ifdef DIVCTRL_DIVZERO_EN
    ,
    .div0      (div0)
`endif
  );

  // Behavioural datapath the controller sequences.
  logic [15:0] rem = '0;
  logic [6:0]  dreg = '0;
  logic [7:0]  addr;
  logic [15:0] muxv;
  assign addr = add ? (rem[15:8] + {1'b0, dreg}) : (rem[15:8] - {1'b0, dreg});
  assign sign = addr[7];
  always_comb begin
    muxv = rem;
    case (sel)
      2'd1:    muxv = {addr, rem[7:0]};
      2'd2:    muxv = {8'd0, dividendin};
      default: muxv = rem;
    endcase
  end
  always @(posedge clk) begin
    if (load) dreg <= divisorin;
    rem <= shift ? {muxv[14:0], inbit} : muxv;
  end

  // Control vector {load, add, shift, inbit, sel, busy, done}.
  logic [7:0] ctrl;
  assign ctrl = {load, add, shift, inbit, sel, busy, done};
  localparam logic [7:0] V_IDLE = {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
  localparam logic [7:0] V_INIT = {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
  localparam logic [7:0] V_SUB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
  localparam logic [7:0] V_RST  = {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
  localparam logic [7:0] V_SH1  = {1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
  localparam logic [7:0] V_DONE = {1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full division; expectations come from integer a/b and a%b.
  task automatic run_div(input logic [7:0] a, input logic [6:0] b, input bit repulse,
                         input string tag);
    logic [7:0] q;
    logic [6:0] r;
    logic [7:0] exp;
    int nrest, nsh;
    q = (b == 0) ? 8'hFF : 8'(a / b);
    r = (b == 0) ? 7'd0 : 7'(a % b);
    nrest = 0;
    nsh = 0;
    @(negedge clk);
    dividendin = a;
    divisorin  = b;
    start      = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      start = repulse && (n == 3 || n == 10);
      if (n == 2) begin
        dividendin = 8'($urandom);
        divisorin  = 7'($urandom);
      end
      if (n == 1) exp = V_INIT;
      else if (n == 18) exp = V_DONE;
      else if (n % 2 == 0) exp = V_SUB;
      else exp = q[7 - (n - 3) / 2] ? V_SH1 : V_RST;
      chk({tag, "_ctrl"}, 32'(ctrl), 32'(exp));
      if (ctrl == V_RST) nrest++;
      if (ctrl == V_SH1) nsh++;
`ifdef DIVCTRL_DIVZERO_EN
      if (n == 1) chk({tag, "_div0_clear"}, 32'(div0), 32'd0);
`endif
    end
    chk({tag, "_quot"}, 32'(rem[7:0]), 32'(q));
    if (b != 0) chk({tag, "_rem"}, 32'(rem[15:9]), 32'(r));
    chk({tag, "_nrestore"}, 32'(nrest), 32'(8 - $countones(q)));
    chk({tag, "_nshift1"}, 32'(nsh), 32'($countones(q)));
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(ctrl), 32'(V_IDLE));
    chk({tag, "_quot_held"}, 32'(rem[7:0]), 32'(q));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(V_IDLE));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 32'(ctrl), 32'(V_IDLE));

    run_div(8'd100, 7'd7, 1'b0, "d100_7");

    // Asynchronous reset in the middle of SUB.
    @(negedge clk);
    dividendin = 8'd200;
    divisorin  = 7'd9;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_sub", 32'(ctrl), 32'(V_SUB));
    reset = 1'b1;
    #1;
    chk("async_reset", 32'(ctrl), 32'(V_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(ctrl), 32'(V_IDLE));
    run_div(8'd77, 7'd5, 1'b0, "after_reset");

    run_div(8'd255, 7'd1, 1'b0, "d255_1");
    run_div(8'd5, 7'd7, 1'b0, "d5_7");
    run_div(8'd100, 7'd7, 1'b1, "repulse");

`ifdef DIVCTRL_DIVZERO_EN
    @(negedge clk);
    dividendin = 8'd42;
    divisorin  = 7'd0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dz_ctrl", 32'(ctrl), 32'(V_DONE));
    chk("dz_div0", 32'(div0), 32'd1);
    @(negedge clk);
    chk("dz_idle", 32'(ctrl), 32'(V_IDLE));
    chk("dz_div0_held", 32'(div0), 32'd1);
    run_div(8'd42, 7'd6, 1'b0, "dz_recover");
`else
    run_div(8'd42, 7'd0, 1'b0, "zero_div");
`endif

    for (int i = 0; i < 6; i++) begin
      run_div(8'($urandom), 7'($urandom_range(127, 1)), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
